// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer that shares one uart_tx_8n1 transmitter between
// NREQ byte producers, with one grant/done handshake per transferred byte.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40000
) (
  input  logic              hwclk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_byte,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  output logic              tx_en,
  input  logic              tx_done,
  output logic              busy,
  input  logic              err_clr,
  output logic              timeout_err
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RELEASE, ABORT} state_t;

  state_t          state, state_next;
  logic            done_meta, done_s;
  logic [IW-1:0]   ptr, ptr_d, owner, owner_d, winner, ptr_after;
  logic            found;
  logic [TW-1:0]   timer, timer_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic [7:0]      tx_byte_d;
  logic            tx_send_d, tx_en_d, err_d;

  // Both flops reset to 1 so an idle transmitter is assumed straight out of reset.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta <= 1'b1;
      done_s    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      done_meta <= tx_done;
      done_s    <= done_meta;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Circular search starting at the priority pointer.
  always_comb begin
    logic [CW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
    if (winner == IW'(NREQ - 1)) ptr_after = '0;
    else                         ptr_after = winner + IW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (done_s && found) state_next = LOAD;
      LOAD:      state_next = WAIT_BUSY;
      WAIT_BUSY: if (!done_s) state_next = WAIT_DONE;
                 else if (timer == TIMER_LAST) state_next = ABORT;
      WAIT_DONE: if (done_s) state_next = RELEASE;
                 else if (timer == TIMER_LAST) state_next = ABORT;
      RELEASE:   state_next = IDLE;
      ABORT:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    grant_d   = '0;
    done_d    = '0;
    tx_byte_d = tx_byte;
    tx_send_d = tx_send;
    tx_en_d   = tx_en;
    owner_d   = owner;
    ptr_d     = ptr;
    timer_d   = timer;
    err_d     = err_clr ? 1'b0 : timeout_err;
    case (state)
      IDLE: begin
        if (done_s && found) begin
          grant_d[winner] = 1'b1;
          tx_byte_d       = req_byte[{winner, 3'b000} +: 8];
          owner_d         = winner;
          ptr_d           = ptr_after;
        end
      end
      LOAD: begin
        tx_send_d = 1'b1;
        tx_en_d   = 1'b1;
        timer_d   = '0;
      end
      WAIT_BUSY: begin
        if (!done_s)            timer_d = '0;
        else if (timer != '1)   timer_d = timer + TW'(1);
      end
      WAIT_DONE: begin
        if (timer != '1) timer_d = timer + TW'(1);
      end
      RELEASE: begin
        tx_send_d     = 1'b0;
        tx_en_d       = 1'b0;
        done_d[owner] = 1'b1;
      end
      ABORT: begin
        tx_send_d = 1'b0;
        tx_en_d   = 1'b0;
        err_d     = 1'b1;  // set wins over a simultaneous err_clr
      end
      default: ;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      done        <= '0;
      tx_byte     <= '0;
      tx_send     <= 1'b0;
      tx_en       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      owner       <= '0;
      ptr         <= '0;
      timer       <= '0;
    end else begin
      grant       <= grant_d;
      done        <= done_d;
      tx_byte     <= tx_byte_d;
      tx_send     <= tx_send_d;
      tx_en       <= tx_en_d;
      busy        <= (state != IDLE);
      timeout_err <= err_d;
      owner       <= owner_d;
      ptr         <= ptr_d;
      timer       <= timer_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx_8n1` transmitter between up to `NREQ` byte producers, such as the RX echo path, a status reporter and a keypad encoder. It sits in the `hwclk` domain between the requesters and the transmitter. It drives the transmitter's `txbyte`/`senddata`/`en` inputs and tracks its `txdone` output, which comes from the 9600 Hz baud domain. It replaces ad-hoc per-top send state counters with a single grant/done handshake per requester.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 40000: `hwclk` cycles allowed per wait phase before a transfer is aborted. One 8N1 frame at 9600 baud from 12 MHz is about 12500 cycles.
- `hwclk`  in  1  system clock, 12 MHz; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester send request, level.
- `req_byte`  in  8*NREQ  byte for requester i in bits [8i+7:8i].
- `grant`  out  NREQ  one-hot, one-cycle pulse: byte of that requester accepted.
- `done`  out  NREQ  one-hot, one-cycle pulse: that requester's byte fully transmitted.
- `tx_byte`  out  8  to transmitter `txbyte`.
- `tx_send`  out  1  to transmitter `senddata`.
- `tx_en`  out  1  to transmitter `en`.
- `tx_done`  in  1  from transmitter `txdone`; asynchronous to `hwclk`.
- `busy`  out  1  high in every state except IDLE.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky: a transfer was aborted.

## Operation
- **`tx_done` synchronizer**
  - 2-flop synchronizer; both flops reset to 1 (transmitter idle).
  - "done_s" below means the synchronizer output.
- **FSM states:** IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RELEASE, ABORT.
- **IDLE**
  - If done_s==1 and any `req` bit is set, pick the winner round-robin.
  - Register `tx_byte` ← winner's byte, pulse `grant[winner]`, record the owner, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - `tx_en`←1, `tx_send`←1, clear the timer, go to WAIT_BUSY.
- **WAIT_BUSY**
  - done_s==0 → clear the timer, go to WAIT_DONE.
  - Timer reaches TIMEOUT−1 → go to ABORT.
- **WAIT_DONE**
  - done_s==1 → go to RELEASE.
  - Timer reaches TIMEOUT−1 → go to ABORT.
- **RELEASE**
  - `tx_send`←0, `tx_en`←0, pulse `done[owner]`, go to IDLE.
- **ABORT**
  - `tx_send`←0, `tx_en`←0, set `timeout_err`, go to IDLE.
  - No `done` pulse.
- **Round-robin priority**
  - A priority pointer holds the index with highest priority; it resets to 0.
  - The search order is pointer, pointer+1, … modulo NREQ.
  - After a grant to i, the pointer becomes (i+1) mod NREQ.
  - An ABORT does not move the pointer beyond that update.
- **Requester rules**
  - Hold `req` and `req_byte` stable until `grant`.
  - Deasserting `req` before its grant withdraws the request with no side effects.
  - `req` bits are ignored outside IDLE.
  - After a grant, the requester may change its byte immediately.
  - A requester re-arbitrates from IDLE for its next byte.
- **Timer**
  - Counter wide enough for TIMEOUT; saturates.
  - Counts only in WAIT_BUSY and WAIT_DONE.
- **`timeout_err`**
  - Set by ABORT.
  - Cleared by `err_clr` when no ABORT occurs in the same cycle; if both occur in the same cycle, set wins.
- **Reset values** (asynchronous, all outputs)
  - Outputs: `grant`=0, `done`=0, `tx_byte`=0, `tx_send`=0, `tx_en`=0, `busy`=0, `timeout_err`=0.
  - Internal: state=IDLE, pointer=0, timer=0.
- **Reset mid-transfer**
  - `tx_send` and `tx_en` drop asynchronously and the transfer is lost.
  - No `done` pulse.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N (with done_s==1) → `grant` and `tx_byte` valid after edge N.
  - `tx_send`/`tx_en` high after edge N+1.
- **`tx_done` sampling:** transitions are seen by the FSM 2–3 cycles late through the synchronizer.
  - The transmitter's `txdone` fall occurs within one baud period (about 1250 `hwclk` cycles).
- **`tx_send` hold:** `tx_send` stays high from LOAD until RELEASE or ABORT.
  - This guarantees the slow-clock transmitter samples it.
- **`done` timing:** `done` pulses one cycle after done_s returns to 1.
  - Minimum gap between `done` and the next `grant` is 1 cycle (RELEASE→IDLE→grant).
- **Pulse widths:** `grant` and `done` are exactly one cycle wide, and never both high in the same cycle.
- **`busy`:** is registered from state, so it is high from the cycle after `grant` until the cycle after RELEASE or ABORT.

## Test plan
- **Single request:** with a transmitter model, `req`=4'b0001 and byte 0x41 → one `grant[0]`, `tx_byte`=0x41, `tx_send` high 1 cycle later, `done[0]` after `txdone` falls and rises; `timeout_err` stays 0.
- **Simultaneous requests:** `req`=4'b1111 held, bytes 0x30..0x33 → grants in order 0,1,2,3 and four serialized frames 0x30,0x31,0x32,0x33.
- **Fairness:** `req[0]` and `req[2]` held continuously → grant order 0,2,0,2; requesters 1 and 3 never granted.
- **Stuck `tx_done`:** `tx_done` held high, `req[1]`=1, TIMEOUT=100 → ABORT about 100 cycles after LOAD; `timeout_err`=1, no `done[1]`, `tx_send`=0.
  - Then pulse `err_clr` → `timeout_err`=0.
- **Reset mid-transfer:** assert `rst_n`=0 during WAIT_DONE → all outputs 0 immediately, no `done`.
  - After release, a new `req[3]` is granted before `req[0]` only if `req[0]` is absent; with both present, 0 wins because the pointer reset to 0.
- **Request withdrawal:** `req[2]` pulsed while busy with requester 0, then dropped → no `grant[2]` after the current transfer.
